// File: rtl/aurora_pkg.sv
// 8b/10b code tables and valid K byte constants shared by the lane encoders.
// Sub-block codes are returned MSB-first in transmit order (abcdei / fghj).
package aurora_pkg;
  localparam int ENCODER_DATA_IN_SIZE  = 8;
  localparam int ENCODER_DATA_OUT_SIZE = 10;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef struct packed {
    logic [5:0] code;
    logic       rd;
  } enc6_t;

  typedef struct packed {
    logic [3:0] code;
    logic       rd;
  } enc4_t;

  function automatic logic is_valid_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == K23_7) || (b == K27_7) ||
           (b == K29_7) || (b == K30_7);
  endfunction

  function automatic enc6_t enc_5b6b(input logic [4:0] x5, input logic k, input logic rd);
    enc6_t r;
    logic [5:0] c;
    logic       flip;
    case (x5)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    if (k && x5 == 5'd28) c = 6'b001111;
    // D.7 is balanced but still has a distinct RD+ form
    flip = ($countones(c) != 3) || (x5 == 5'd7 && !k);
    if (rd && flip) c = ~c;
    r.code = c;
    r.rd   = ($countones(c) > 3) ? 1'b1 : ($countones(c) < 3) ? 1'b0 : rd;
    return r;
  endfunction

  function automatic enc4_t enc_3b4b(input logic [2:0] x3, input logic k, input logic rd,
                                     input logic a7);
    enc4_t r;
    logic [3:0] c;
    case (x3)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;
      default: c = a7 ? 4'b0111 : 4'b1110;
    endcase
    // K28 balanced 4b codes take the complemented form when entering at RD-
    if (k && (x3 == 3'd1 || x3 == 3'd2 || x3 == 3'd5 || x3 == 3'd6)) begin
      if (!rd) c = ~c;
    end else if (rd && (($countones(c) != 2) || x3 == 3'd3 || x3 == 3'd7)) begin
      c = ~c;
    end
    r.code = c;
    r.rd   = ($countones(c) > 2) ? 1'b1 : ($countones(c) < 2) ? 1'b0 : rd;
    return r;
  endfunction
endpackage

// File: rtl/encoder_8b10b.sv
// Registered per-lane 8b/10b encoder with running disparity tracking.
// Optional invalid-K detection enabled by defining AURORA_ENCODER_K_CHECK_EN.
module encoder_8b10b
  import aurora_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             ctrl_in,
  input  logic [ENCODER_DATA_IN_SIZE-1:0]  data_in,
  output logic [ENCODER_DATA_OUT_SIZE-1:0] data_out,
  output logic                             rd_out,
  output logic                             code_err
);
  logic       bad_k, k_use, a7;
  logic [4:0] x;
  enc6_t      e6;
  enc4_t      e4;
  logic [9:0] grp;

  assign x = data_in[4:0];

  always_comb begin
`ifdef AURORA_ENCODER_K_CHECK_EN
    bad_k = ctrl_in && !is_valid_k(data_in);
`else
    bad_k = 1'b0;
`endif
    k_use = ctrl_in && !bad_k;
    e6    = enc_5b6b(x, k_use, rd_out);
    // A7 avoids a run of five identical bits across the 6b/4b boundary
    a7    = (data_in[7:5] == 3'd7) &&
            (k_use || (e6.rd ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                             : (x == 5'd17 || x == 5'd18 || x == 5'd20)));
    e4    = enc_3b4b(data_in[7:5], k_use, e6.rd, a7);
    for (int i = 0; i < 6; i++) grp[i]     = e6.code[5-i];
    for (int i = 0; i < 4; i++) grp[6 + i] = e4.code[3-i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_out   <= 1'b0;
      code_err <= 1'b0;
    end else if (en) begin
      data_out <= grp;
      rd_out   <= e4.rd;
      code_err <= bad_k;
    end else begin
      code_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_encoder_8b10b.sv
// Self-checking bench for encoder_8b10b: running-digital-sum model plus literal pins.
module tb_encoder_8b10b;
  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, ctrl_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [9:0] data_out;
  logic       rd_out, code_err;

  int checks = 0, failures = 0;

  encoder_8b10b dut (.clk(clk), .rst(rst), .en(en), .ctrl_in(ctrl_in), .data_in(data_in),
                     .data_out(data_out), .rd_out(rd_out), .code_err(code_err));

  always #5 clk = ~clk;

  // Code tables in transmit order (MSB = first bit on the wire)
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4M [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KSET [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                       8'hF7, 8'hFB, 8'hFD, 8'hFE};

  function automatic logic is_k(input logic [7:0] b);
    logic r = 1'b0;
    for (int i = 0; i < 12; i++) if (KSET[i] == b) r = 1'b1;
    return r;
  endfunction

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // RD is the sign of the running digital sum: RD+ iff more ones than zeros so far
  function automatic void model_enc(input logic [7:0] d, input logic k, input int s_in,
                                    output logic [9:0] code, output int s_out);
    int s = s_in;
    logic [4:0] x = d[4:0];
    logic [2:0] y = d[7:5];
    logic [5:0] c6;
    logic [3:0] c4;
    logic alt;
    if (k && x == 5'd28) c6 = (s > 0) ? 6'b110000 : 6'b001111;
    else begin
      c6 = T6[x];
      if (s > 0 && ($countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
    end
    s = s + 2 * $countones(c6) - 6;
    if (k && x == 5'd28) c4 = (s > 0) ? K4P[y] : K4M[y];
    else begin
      alt = (y == 3'd7) && (k || (s <= 0 && (x == 17 || x == 18 || x == 20)) ||
                                 (s > 0 && (x == 11 || x == 13 || x == 14)));
      if (alt) c4 = (s > 0) ? 4'b1000 : 4'b0111;
      else     c4 = (s > 0) ? D4P[y] : D4M[y];
    end
    s = s + 2 * $countones(c4) - 4;
    code  = {c6, c4};
    s_out = s;
  endfunction

  // Model state, updated on the same edge as the DUT
  logic [9:0] m_code = '0;
  int         m_rds = 0;
  logic       m_rd = 1'b0, m_err = 1'b0, m_known = 1'b0, m_started = 1'b0;
  logic [9:0] nx_code;
  int         nx_rds;
  logic       nx_bad, use_k;

  // Literal expectations, pipelined alongside the byte they belong to
  logic       lv = 1'b0, lchk = 1'b0, lrd = 1'b0, lerr = 1'b0;
  logic [9:0] lcode = '0;
  logic       m_lv = 1'b0, m_lchk = 1'b0, m_lrd = 1'b0, m_lerr = 1'b0;
  logic [9:0] m_lcode = '0;

  always_comb begin
    nx_code = '0;
    nx_rds  = 0;
    nx_bad  = ctrl_in && !is_k(data_in);
`ifdef AURORA_ENCODER_K_CHECK_EN
    use_k   = ctrl_in && !nx_bad;
`else
    use_k   = ctrl_in;
`endif
    model_enc(data_in, use_k, m_rds, nx_code, nx_rds);
  end

  always @(posedge clk) begin
    m_lv <= lv; m_lchk <= lchk; m_lcode <= lcode; m_lrd <= lrd; m_lerr <= lerr;
    if (rst) begin
      m_started <= 1'b1; m_known <= 1'b1;
      m_code <= '0; m_rds <= 0; m_rd <= 1'b0; m_err <= 1'b0;
    end else if (en) begin
      m_code <= nx_code; m_rds <= nx_rds; m_rd <= (nx_rds > 0);
`ifdef AURORA_ENCODER_K_CHECK_EN
      m_err <= nx_bad;
`else
      m_err <= 1'b0;
      if (nx_bad) m_known <= 1'b0;
`endif
    end else begin
      m_err <= 1'b0;
    end
  end

  task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      if (m_known) begin
        cmp("model_data", rev10(data_out), m_code);
        cmp("model_rd", {9'b0, rd_out}, {9'b0, m_rd});
      end
      cmp("model_err", {9'b0, code_err}, {9'b0, m_err});
      if (m_lv) begin
        if (m_lchk) begin
          cmp("lit_data", rev10(data_out), m_lcode);
          cmp("lit_rd", {9'b0, rd_out}, {9'b0, m_lrd});
        end
        cmp("lit_err", {9'b0, code_err}, {9'b0, m_lerr});
      end
    end
  end

  task automatic want(input logic [9:0] c, input logic r, input logic e, input logic chk = 1'b1);
    lv = 1'b1; lchk = chk; lcode = c; lrd = r; lerr = e;
  endtask

  task automatic drive(input logic r, input logic e, input logic c, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; ctrl_in = c; data_in = d;
    @(posedge clk);
    #1 lv = 1'b0;
  endtask

  initial begin
    want(10'b0, 1'b0, 1'b0); drive(1, 0, 0, 8'h00);
    want(10'b0, 1'b0, 1'b0); drive(1, 1, 1, 8'hBC);
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 1, 1, 8'hBC);
    want(10'b1100000101, 1'b0, 1'b0); drive(0, 1, 1, 8'hBC);
    want(10'b1010101010, 1'b0, 1'b0); drive(0, 1, 0, 8'hB5);
    want(10'b1001110100, 1'b0, 1'b0); drive(0, 1, 0, 8'h00);
    want(10'b1000110111, 1'b1, 1'b0); drive(0, 1, 0, 8'hF1);
    want(10'b1100000101, 1'b0, 1'b0); drive(0, 1, 1, 8'hBC);
    want(10'b1100011110, 1'b1, 1'b0); drive(0, 1, 0, 8'hE3);
    want(10'b1100000101, 1'b0, 1'b0); drive(0, 1, 1, 8'hBC);
    // enable gaps hold the output and RD
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 1, 1, 8'hBC);
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 0, 1, 8'hBC);
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 0, 1, 8'hBC);
    want(10'b1100000101, 1'b0, 1'b0); drive(0, 1, 1, 8'hBC);
`ifdef AURORA_ENCODER_K_CHECK_EN
    want(10'b1001110100, 1'b0, 1'b1); drive(0, 1, 1, 8'h00);
    want(10'b1001110100, 1'b0, 1'b0); drive(0, 0, 0, 8'h00);
    want(10'b1010101010, 1'b0, 1'b0); drive(0, 1, 0, 8'hB5);
`else
    want(10'b0, 1'b0, 1'b0, 1'b0); drive(0, 1, 1, 8'h00);
    want(10'b0, 1'b0, 1'b0); drive(1, 0, 0, 8'h00);
`endif
    // reset while RD+ discards the in-flight byte
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 1, 1, 8'hBC);
    want(10'b0, 1'b0, 1'b0); drive(1, 1, 1, 8'hBC);
    want(10'b0011111010, 1'b1, 1'b0); drive(0, 1, 1, 8'hBC);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b = i[7:0];
      drive(0, (i % 5) != 4, 0, b);
    end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 12; j++) drive(0, $urandom_range(0, 3) != 0, 1, KSET[j]);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) drive(0, 1, 1, KSET[$urandom_range(0, 11)]);
      else drive(0, 1, 0, b);
    end
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
